// File: rtl/final_w_pkg.sv
// Shared types and default timing constants for the final-weight capture block.
package final_w_pkg;

  // Capture FSM states.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_GAP  = 2'd3
  } state_t;

  // Default frame timing, in counter values.
  localparam int FRAME_LEN_D    = 1026;
  localparam int CAPTURE_CNT_D  = 61;
  localparam int HOLD_END_CNT_D = 512;

endpackage : final_w_pkg

// File: rtl/final_w_frame_ctr.sv
// Free-running frame counter with enable and wrap, plus decoded position strobes.
// The counter is parked at 0 while I_en is low.
// O_is_hold_end marks the last cycle the captured value is visible (HOLD_END_CNT+1).
module final_w_frame_ctr
  import final_w_pkg::*;
#(
  parameter int CNT_W        = 11,
  parameter int FRAME_LEN    = FRAME_LEN_D,
  parameter int CAPTURE_CNT  = CAPTURE_CNT_D,
  parameter int HOLD_END_CNT = HOLD_END_CNT_D
) (
  input  logic             I_sys_clk,
  input  logic             I_sys_rstn,
  input  logic             I_en,
  output logic [CNT_W-1:0] O_cnt,
  output logic             O_is_capture,
  output logic             O_is_hold_end,
  output logic             O_is_wrap
);

  localparam logic [CNT_W-1:0] WRAP_V = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] CAP_V  = CNT_W'(CAPTURE_CNT);
  localparam logic [CNT_W-1:0] HEND_V = CNT_W'(HOLD_END_CNT + 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: park at 0 when disabled, wrap at the end of the frame.
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (!I_en || (cnt_q == WRAP_V)) begin
      cnt_d = '0;
    end
  end

  // Counter register.
  always_ff @(posedge I_sys_clk or negedge I_sys_rstn) begin
    if (!I_sys_rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign O_cnt         = cnt_q;
  assign O_is_capture  = (cnt_q == CAP_V);
  assign O_is_hold_end = (cnt_q == HEND_V);
  assign O_is_wrap     = (cnt_q == WRAP_V);

endmodule : final_w_frame_ctr

// File: rtl/final_w_capture.sv
// Frame-synchronous capture of CH_NUM normalised weights into held outputs.
// Optional build macro: FINAL_W_HOLD_LAST_EN -- when defined, O_w_final keeps
// the last good capture after the hold window and across missed frames; it is
// then cleared only by reset or by dropping I_en.
//
// state  | meaning
// S_IDLE | disabled, counter parked at 0
// S_WAIT | running, waiting for the capture count
// S_HOLD | capture taken, outputs valid until the hold-end count
// S_GAP  | hold finished or capture missed, waiting for the frame wrap
module final_w_capture
  import final_w_pkg::*;
#(
  parameter int CH_NUM       = 2,
  parameter int DW           = 32,
  parameter int CNT_W        = 11,
  parameter int FRAME_LEN    = FRAME_LEN_D,
  parameter int CAPTURE_CNT  = CAPTURE_CNT_D,
  parameter int HOLD_END_CNT = HOLD_END_CNT_D
) (
  input  logic                 I_sys_clk,
  input  logic                 I_sys_rstn,
  input  logic                 I_en,
  input  logic [CH_NUM*DW-1:0] I_w_normalize,
  input  logic                 I_w_valid,
  output logic [CH_NUM*DW-1:0] O_w_final,
  output logic                 O_w_valid,
  output logic                 O_capture_pulse,
  output logic                 O_capture_miss,
  output logic [CNT_W-1:0]     O_frame_cnt
);

  if (!((CAPTURE_CNT >= 0) && (CAPTURE_CNT < HOLD_END_CNT) &&
        (HOLD_END_CNT < FRAME_LEN - 1) && (FRAME_LEN <= (1 << CNT_W)))) begin : g_param_err
    $error("final_w_capture: illegal frame timing parameters");
  end

  state_t state_q, state_d;
  logic   w_valid_q, w_valid_d;
  logic   pulse_q, pulse_d;
  logic   miss_q, miss_d;
  logic   cap_load;
  logic   final_clr;

  logic   is_capture;
  logic   is_hold_end;
  logic   is_wrap;

  final_w_frame_ctr #(
    .CNT_W        (CNT_W),
    .FRAME_LEN    (FRAME_LEN),
    .CAPTURE_CNT  (CAPTURE_CNT),
    .HOLD_END_CNT (HOLD_END_CNT)
  ) u_frame_ctr (
    .I_sys_clk     (I_sys_clk),
    .I_sys_rstn    (I_sys_rstn),
    .I_en          (I_en),
    .O_cnt         (O_frame_cnt),
    .O_is_capture  (is_capture),
    .O_is_hold_end (is_hold_end),
    .O_is_wrap     (is_wrap)
  );

  // FSM next state and capture/clear controls; disable overrides everything.
  always_comb begin
    state_d   = state_q;
    w_valid_d = w_valid_q;
    pulse_d   = 1'b0;
    miss_d    = 1'b0;
    cap_load  = 1'b0;
    final_clr = 1'b0;
    if (!I_en) begin
      state_d   = S_IDLE;
      w_valid_d = 1'b0;
      final_clr = 1'b1;
    end else begin
      case (state_q)
        // IDLE shares the WAIT decode so a capture count of 0 is not skipped.
        S_IDLE, S_WAIT: begin
          state_d = S_WAIT;
          if (is_capture) begin
            if (I_w_valid) begin
              state_d   = S_HOLD;
              cap_load  = 1'b1;
              w_valid_d = 1'b1;
              pulse_d   = 1'b1;
            end else begin
              state_d = S_GAP;
              miss_d  = 1'b1;
            end
          end
        end
        S_HOLD: begin
          if (is_hold_end) begin
            w_valid_d = 1'b0;
`ifndef FINAL_W_HOLD_LAST_EN
            final_clr = 1'b1;
`endif
            // Hold end may coincide with the wrap when HOLD_END_CNT = FRAME_LEN-2.
            state_d = is_wrap ? S_WAIT : S_GAP;
          end
        end
        S_GAP: begin
          if (is_wrap) begin
            state_d = S_WAIT;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // FSM state and registered status outputs.
  always_ff @(posedge I_sys_clk or negedge I_sys_rstn) begin
    if (!I_sys_rstn) begin
      state_q   <= S_IDLE;
      w_valid_q <= 1'b0;
      pulse_q   <= 1'b0;
      miss_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      w_valid_q <= w_valid_d;
      pulse_q   <= pulse_d;
      miss_q    <= miss_d;
    end
  end

  assign O_w_valid       = w_valid_q;
  assign O_capture_pulse = pulse_q;
  assign O_capture_miss  = miss_q;

  for (genvar k = 0; k < CH_NUM; k++) begin : g_ch
    logic [DW-1:0] w_final_q;

    // Per-channel capture register: clear wins over load.
    always_ff @(posedge I_sys_clk or negedge I_sys_rstn) begin
      if (!I_sys_rstn) begin
        w_final_q <= '0;
      end else if (final_clr) begin
        w_final_q <= '0;
      end else if (cap_load) begin
        w_final_q <= I_w_normalize[k*DW +: DW];
      end
    end

    assign O_w_final[k*DW +: DW] = w_final_q;
  end

endmodule : final_w_capture
